// File: rtl/wb_pkg.sv
// Shared types and constants for the write-back arbiter.
//   WB_ADDR_W   default register address width (32 registers)
//   WB_DATA_W   default result width
//   NUM_REGS    number of architectural registers
//   wb_entry_t  one queued write: destination, data, live flag
package wb_pkg;

    localparam int WB_ADDR_W = 5;
    localparam int WB_DATA_W = 32;
    localparam int NUM_REGS  = 32;

    // A dead entry (live=0) still occupies a FIFO slot but must not write
    // the register file when it retires.
    typedef struct packed {
        logic [WB_ADDR_W-1:0] rd;
        logic [WB_DATA_W-1:0] data;
        logic                 live;
    } wb_entry_t;

endpackage

// File: rtl/wb_fifo.sv
// Circular buffer of pending ALU write-backs.
//   clk, rst        system clock, synchronous active-high reset
//   push/push_entry write an entry at the tail (ignored when full)
//   pop/head        retire the head entry (ignored when empty)
//   kill_en/kill_rd clear live on every stored entry whose rd matches;
//                   an entry pushed at the same edge is not affected
//   count/full/empty occupancy
//   entry_rd/live   per-slot destination and live flag for busy generation;
//                   live is cleared on pop, so live=1 implies occupied
module wb_fifo
    import wb_pkg::*;
#(
    parameter int DEPTH = 4
) (
    input  logic                            clk,
    input  logic                            rst,
    input  logic                            push,
    input  wb_entry_t                       push_entry,
    input  logic                            pop,
    output wb_entry_t                       head,
    input  logic                            kill_en,
    input  logic [WB_ADDR_W-1:0]            kill_rd,
    output logic [$clog2(DEPTH):0]          count,
    output logic                            full,
    output logic                            empty,
    output logic [DEPTH-1:0][WB_ADDR_W-1:0] entry_rd,
    output logic [DEPTH-1:0]                entry_live
);

    localparam int PTR_W = $clog2(DEPTH);
    localparam int CNT_W = PTR_W + 1;

    wb_entry_t        mem [DEPTH];
    logic [PTR_W-1:0] rd_ptr;
    logic [PTR_W-1:0] wr_ptr;
    logic             do_push;
    logic             do_pop;

    always_comb begin
        full    = (count == CNT_W'(DEPTH));
        empty   = (count == '0);
        do_push = push && !full;
        do_pop  = pop && !empty;
        head    = mem[rd_ptr];
        for (int i = 0; i < DEPTH; i++) begin
            entry_rd[i]   = mem[i].rd;
            entry_live[i] = mem[i].live;
        end
    end

    // Later assignments win: the pushed entry overrides any kill/pop effect
    // on its slot (the tail slot is never occupied when a push is legal).
    always_ff @(posedge clk) begin
        if (rst) begin
            rd_ptr <= '0;
            wr_ptr <= '0;
            count  <= '0;
            for (int i = 0; i < DEPTH; i++) begin
                mem[i].live <= 1'b0;
            end
        end else begin
            if (kill_en) begin
                for (int i = 0; i < DEPTH; i++) begin
                    if (mem[i].rd == kill_rd) begin
                        mem[i].live <= 1'b0;
                    end
                end
            end
            if (do_pop) begin
                mem[rd_ptr].live <= 1'b0;
                rd_ptr           <= rd_ptr + PTR_W'(1);
            end
            if (do_push) begin
                mem[wr_ptr] <= push_entry;
                wr_ptr      <= wr_ptr + PTR_W'(1);
            end
            count <= count + CNT_W'(do_push) - CNT_W'(do_pop);
        end
    end

endmodule

// File: rtl/writeback_arbiter.sv
// Write-back arbiter feeding the register file's single write port.
// Load returns (unbuffered) take absolute priority over ALU results, which
// wait in wb_fifo. A load kills older queued ALU writes to the same register
// so that register-file contents follow program (arrival) order.
//   clk, rst                      clock, synchronous active-high reset
//   alu_valid/alu_ready/alu_rd/alu_data  ALU result stream (valid/ready)
//   ld_valid/ld_rd/ld_data        load return, always accepted
//   rw/end3/data3                 registered register-file write port
//   busy                          per-register pending-write scoreboard
//   fifo_empty                    no ALU entries queued
// Optional build macro WB_ZERO_REG_GUARD_EN: register 0 is never written and
// never reported busy.
// ADDR_W/DATA_W must match the wb_pkg entry widths.
module writeback_arbiter
    import wb_pkg::*;
#(
    parameter int DEPTH  = 4,
    parameter int DATA_W = WB_DATA_W,
    parameter int ADDR_W = WB_ADDR_W
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                alu_valid,
    output logic                alu_ready,
    input  logic [ADDR_W-1:0]   alu_rd,
    input  logic [DATA_W-1:0]   alu_data,
    input  logic                ld_valid,
    input  logic [ADDR_W-1:0]   ld_rd,
    input  logic [DATA_W-1:0]   ld_data,
    output logic                rw,
    output logic [ADDR_W-1:0]   end3,
    output logic [DATA_W-1:0]   data3,
    output logic [NUM_REGS-1:0] busy,
    output logic                fifo_empty
);

    localparam int CNT_W = $clog2(DEPTH) + 1;

`ifdef WB_ZERO_REG_GUARD_EN
    localparam bit ZERO_GUARD = 1'b1;
`else
    localparam bit ZERO_GUARD = 1'b0;
`endif

    logic                            fifo_push;
    logic                            fifo_pop;
    logic                            kill_en;
    wb_entry_t                       push_entry;
    wb_entry_t                       head;
    logic [CNT_W-1:0]                fifo_count;
    logic                            fifo_full;
    logic                            fifo_is_empty;
    logic [DEPTH-1:0][WB_ADDR_W-1:0] entry_rd;
    logic [DEPTH-1:0]                entry_live;
    logic                            ld_write;

    always_comb begin
        alu_ready       = !rst && !fifo_full;
        fifo_push       = alu_valid && alu_ready;
        fifo_pop        = !rst && !ld_valid && !fifo_is_empty;
        kill_en         = !rst && ld_valid;
        push_entry.rd   = alu_rd;
        push_entry.data = alu_data;
        push_entry.live = !(ZERO_GUARD && (alu_rd == '0));
        ld_write        = !(ZERO_GUARD && (ld_rd == '0));
        fifo_empty      = (fifo_count == '0);
    end

    wb_fifo #(
        .DEPTH (DEPTH)
    ) u_fifo (
        .clk        (clk),
        .rst        (rst),
        .push       (fifo_push),
        .push_entry (push_entry),
        .pop        (fifo_pop),
        .head       (head),
        .kill_en    (kill_en),
        .kill_rd    (ld_rd),
        .count      (fifo_count),
        .full       (fifo_full),
        .empty      (fifo_is_empty),
        .entry_rd   (entry_rd),
        .entry_live (entry_live)
    );

    // A dead head still retires through the output stage (address/data are
    // loaded) but with the write enable low.
    always_ff @(posedge clk) begin
        if (rst) begin
            rw    <= 1'b0;
            end3  <= '0;
            data3 <= '0;
        end else if (ld_valid) begin
            rw    <= ld_write;
            end3  <= ld_rd;
            data3 <= ld_data;
        end else if (fifo_pop) begin
            rw    <= head.live;
            end3  <= head.rd;
            data3 <= head.data;
        end else begin
            rw    <= 1'b0;
        end
    end

    always_comb begin
        busy = '0;
        for (int i = 0; i < DEPTH; i++) begin
            if (entry_live[i]) begin
                busy[entry_rd[i]] = 1'b1;
            end
        end
        if (rw) begin
            busy[end3] = 1'b1;
        end
        if (ZERO_GUARD) begin
            busy[0] = 1'b0;
        end
    end

endmodule

// File: tb/tb_writeback_arbiter.sv
module tb_writeback_arbiter;

`ifdef WB_ZERO_REG_GUARD_EN
    localparam bit GUARD = 1'b1;
`else
    localparam bit GUARD = 1'b0;
`endif

    logic        clk;
    logic        rst;
    logic        alu_valid;
    logic        alu_ready;
    logic [4:0]  alu_rd;
    logic [31:0] alu_data;
    logic        ld_valid;
    logic [4:0]  ld_rd;
    logic [31:0] ld_data;
    logic        rw;
    logic [4:0]  end3;
    logic [31:0] data3;
    logic [31:0] busy;
    logic        fifo_empty;

    int checks = 0;
    int errors = 0;

    writeback_arbiter #(
        .DEPTH  (4),
        .DATA_W (32),
        .ADDR_W (5)
    ) dut (
        .clk        (clk),
        .rst        (rst),
        .alu_valid  (alu_valid),
        .alu_ready  (alu_ready),
        .alu_rd     (alu_rd),
        .alu_data   (alu_data),
        .ld_valid   (ld_valid),
        .ld_rd      (ld_rd),
        .ld_data    (ld_data),
        .rw         (rw),
        .end3       (end3),
        .data3      (data3),
        .busy       (busy),
        .fifo_empty (fifo_empty)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        if (obs !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", tag, obs, exp);
        end
    endtask

    // Advance one posedge; outputs are then sampled 1 time unit later.
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic alu(input logic v, input logic [4:0] rd, input logic [31:0] d);
        alu_valid = v;
        alu_rd    = rd;
        alu_data  = d;
    endtask

    task automatic ld(input logic v, input logic [4:0] rd, input logic [31:0] d);
        ld_valid = v;
        ld_rd    = rd;
        ld_data  = d;
    endtask

    initial begin
        rst = 1'b1;
        alu(1'b0, 5'd0, 32'h0);
        ld(1'b0, 5'd0, 32'h0);

        // Reset then idle
        tick();
        tick();
        chk("rst_rw", {31'b0, rw}, 32'd0);
        chk("rst_busy", busy, 32'd0);
        chk("rst_empty", {31'b0, fifo_empty}, 32'd1);
        chk("rst_ready", {31'b0, alu_ready}, 32'd0);
        rst = 1'b0;
        tick();
        chk("ready_after_rst", {31'b0, alu_ready}, 32'd1);
        chk("idle_rw", {31'b0, rw}, 32'd0);

        // Single ALU write rd=5
        alu(1'b1, 5'd5, 32'h0000_00A5);
        tick();
        alu(1'b0, 5'd0, 32'h0);
        chk("alu1_busy_q", busy, 32'h0000_0020);
        chk("alu1_rw_q", {31'b0, rw}, 32'd0);
        chk("alu1_empty_q", {31'b0, fifo_empty}, 32'd0);
        tick();
        chk("alu1_rw", {31'b0, rw}, 32'd1);
        chk("alu1_end3", {27'b0, end3}, 32'd5);
        chk("alu1_data3", data3, 32'h0000_00A5);
        chk("alu1_busy_out", busy, 32'h0000_0020);
        tick();
        chk("alu1_rw_done", {31'b0, rw}, 32'd0);
        chk("alu1_busy_done", busy, 32'd0);
        chk("alu1_end3_hold", {27'b0, end3}, 32'd5);

        // Fill the FIFO under a continuous load to r9
        ld(1'b1, 5'd9, 32'h0000_0099);
        for (int i = 1; i <= 4; i++) begin
            alu(1'b1, 5'(i), 32'h100 + 32'(i));
            tick();
            chk("fill_ld_rw", {31'b0, rw}, 32'd1);
            chk("fill_ld_end3", {27'b0, end3}, 32'd9);
        end
        alu(1'b0, 5'd0, 32'h0);
        chk("full_ready", {31'b0, alu_ready}, 32'd0);
        chk("full_busy", busy, 32'h0000_021E);
        chk("full_data3", data3, 32'h0000_0099);
        ld(1'b0, 5'd0, 32'h0);
        for (int i = 1; i <= 4; i++) begin
            tick();
            chk("drain_rw", {31'b0, rw}, 32'd1);
            chk("drain_end3", {27'b0, end3}, 32'(i));
            chk("drain_data3", data3, 32'h100 + 32'(i));
        end
        chk("drain_ready", {31'b0, alu_ready}, 32'd1);
        tick();
        chk("drain_rw_done", {31'b0, rw}, 32'd0);
        chk("drain_empty", {31'b0, fifo_empty}, 32'd1);

        // Queued ALU r7 killed by a younger load to r7
        alu(1'b1, 5'd7, 32'h0000_0011);
        tick();
        alu(1'b0, 5'd0, 32'h0);
        chk("kill_busy_q", busy, 32'h0000_0080);
        ld(1'b1, 5'd7, 32'h0000_0022);
        tick();
        ld(1'b0, 5'd0, 32'h0);
        chk("kill_ld_rw", {31'b0, rw}, 32'd1);
        chk("kill_ld_end3", {27'b0, end3}, 32'd7);
        chk("kill_ld_data3", data3, 32'h0000_0022);
        chk("kill_ld_busy", busy, 32'h0000_0080);
        tick();
        chk("kill_dead_rw", {31'b0, rw}, 32'd0);
        chk("kill_busy_clr", busy, 32'd0);
        chk("kill_empty", {31'b0, fifo_empty}, 32'd1);

        // Same-edge load and ALU push to r3: load first
        ld(1'b1, 5'd3, 32'h0000_0033);
        alu(1'b1, 5'd3, 32'h0000_0044);
        tick();
        ld(1'b0, 5'd0, 32'h0);
        alu(1'b0, 5'd0, 32'h0);
        chk("same_ld_rw", {31'b0, rw}, 32'd1);
        chk("same_ld_data3", data3, 32'h0000_0033);
        chk("same_busy", busy, 32'h0000_0008);
        tick();
        chk("same_alu_rw", {31'b0, rw}, 32'd1);
        chk("same_alu_end3", {27'b0, end3}, 32'd3);
        chk("same_alu_data3", data3, 32'h0000_0044);
        tick();
        chk("same_busy_clr", busy, 32'd0);

        // ALU write to r0
        alu(1'b1, 5'd0, 32'hFFFF_FFFF);
        tick();
        alu(1'b0, 5'd0, 32'h0);
        chk("r0_busy_q", busy, GUARD ? 32'd0 : 32'd1);
        tick();
        chk("r0_rw", {31'b0, rw}, GUARD ? 32'd0 : 32'd1);
        chk("r0_end3", {27'b0, end3}, 32'd0);
        chk("r0_busy", busy, GUARD ? 32'd0 : 32'd1);
        tick();

        // Reset mid-operation discards queued and in-flight writes
        alu(1'b1, 5'd10, 32'h0000_00AA);
        tick();
        alu(1'b1, 5'd11, 32'h0000_00BB);
        tick();
        rst = 1'b1;
        ld(1'b1, 5'd12, 32'h0000_00CC);
        tick();
        chk("mrst_rw", {31'b0, rw}, 32'd0);
        chk("mrst_busy", busy, 32'd0);
        chk("mrst_empty", {31'b0, fifo_empty}, 32'd1);
        chk("mrst_ready", {31'b0, alu_ready}, 32'd0);
        chk("mrst_data3", data3, 32'd0);
        rst = 1'b0;
        alu(1'b0, 5'd0, 32'h0);
        ld(1'b0, 5'd0, 32'h0);
        tick();
        chk("mrst_idle_rw", {31'b0, rw}, 32'd0);
        chk("mrst_idle_ready", {31'b0, alu_ready}, 32'd1);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
